// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - fetch front-end bus: PC input, memory request/response and decode handshakes
interface ifu_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] pc;
  logic              flush;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic              mem_rsp_ready;
  logic [DATA_W-1:0] mem_rsp_data;
  logic              mem_rsp_err;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic [1:0]        inst_fault;
  logic              pc_wen;
  logic              busy;

  modport master (
    input  pc, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err, inst_ready,
    output mem_req_valid, mem_req_addr, mem_rsp_ready, inst_valid, inst, inst_pc, inst_fault,
           pc_wen, busy
  );

  modport slave (
    output pc, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err, inst_ready,
    input  mem_req_valid, mem_req_addr, mem_rsp_ready, inst_valid, inst, inst_pc, inst_fault,
           pc_wen, busy
  );
endinterface

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch front end: PC -> memory read -> decode handoff, drives PC wen
module ifu_fetch #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic         clk,
  input logic         rst,
  ifu_fetch_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [1:0] F_NONE    = 2'b00;
  localparam logic [1:0] F_MIS     = 2'b01;
  localparam logic [1:0] F_BUS     = 2'b10;
  localparam logic [1:0] F_TMO     = 2'b11;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic [1:0]        fault_q, fault_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              flush_q, flush_d;
  logic [7:0]        cnt_inc;
  logic              drain;

  assign cnt_inc = cnt_q + 8'd1;
  // A redirect seen at any point of the memory transaction discards its response.
  assign drain   = flush_q | bus.flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      fault_q   <= F_NONE;
      cnt_q     <= '0;
      flush_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      fault_q   <= fault_d;
      cnt_q     <= cnt_d;
      flush_q   <= flush_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    pc_d              = pc_q;
    inst_d            = inst_q;
    inst_pc_d         = inst_pc_q;
    fault_d           = fault_q;
    cnt_d             = cnt_q;
    flush_d           = flush_q;
    bus.mem_req_valid = 1'b0;
    bus.mem_rsp_ready = 1'b0;
    bus.inst_valid    = 1'b0;
    bus.pc_wen        = 1'b0;
    bus.mem_req_addr  = pc_q;
    bus.inst          = inst_q;
    bus.inst_pc       = inst_pc_q;
    bus.inst_fault    = fault_q;
    bus.busy          = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        pc_d = bus.pc;
        if (!bus.flush) begin
          if (bus.pc[1:0] != 2'b00) begin
            inst_d    = '0;
            inst_pc_d = bus.pc;
            fault_d   = F_MIS;
            state_d   = S_HOLD;
          end else begin
            state_d = S_REQ;
          end
        end
      end

      S_REQ: begin
        bus.mem_req_valid = 1'b1;
        if (bus.flush) flush_d = 1'b1;
        if (bus.mem_req_ready) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        bus.mem_rsp_ready = 1'b1;
        if (bus.flush) flush_d = 1'b1;
        if (bus.mem_rsp_valid) begin
          if (drain) begin
            state_d = S_DRAIN;
          end else begin
            inst_d    = bus.mem_rsp_data;
            inst_pc_d = pc_q;
            fault_d   = bus.mem_rsp_err ? F_BUS : F_NONE;
            state_d   = S_HOLD;
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_C) begin
            if (drain) begin
              state_d = S_DRAIN;
            end else begin
              inst_d    = '0;
              inst_pc_d = pc_q;
              fault_d   = F_TMO;
              state_d   = S_HOLD;
            end
          end
        end
      end

      S_HOLD: begin
        bus.inst_valid = 1'b1;
        // Redirect beats a same-cycle accept: the PC must not also step to dnpc.
        if (bus.flush) begin
          state_d = S_IDLE;
        end else if (bus.inst_ready) begin
          bus.pc_wen = 1'b1;
          state_d    = S_IDLE;
        end
      end

      S_DRAIN: begin
        flush_d = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
